// File: rtl/clk_div_pkg.sv
// Shared constants and config record for the multi-channel clock divider.
// Phase-offset support is selected by macro CLKDIV_PHASE_EN in the channel file.
package clk_div_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int MIN_DIV   = 2;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DIV_W_DEF-1:0] high;
        logic [DIV_W_DEF-1:0] phase;
    } clk_div_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active config, pending apply and lock.
// Macro CLKDIV_PHASE_EN adds a per-channel start-phase register.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_high,
    input  logic [DIV_W-1:0] i_phase,
    output logic             o_clk,
    output logic             o_stb,
    output logic             o_lock
);

    localparam logic [DIV_W-1:0] L_MIN_DIV = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] L_ONE     = DIV_W'(1);

    logic [DIV_W-1:0] r_sh_div;
    logic [DIV_W-1:0] r_sh_high;
    logic [DIV_W-1:0] r_act_div;
    logic [DIV_W-1:0] r_act_high;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_run;
    logic             r_armed;
    logic             r_clk;
    logic             r_stb;
    logic             r_lock;

    logic [DIV_W-1:0] w_wr_div;
    logic [DIV_W-1:0] w_wr_high;
    logic [DIV_W-1:0] w_nxt_high;
    logic [DIV_W-1:0] w_start;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_running;
    logic             w_wrap;
    logic             w_apply;
    logic             w_armed_nxt;
    logic             w_lock_nxt;
    logic             w_clk_nxt;
    logic             w_stb_nxt;

    // Clamp at write time so the shadow always holds a legal config.
    always_comb begin
        w_wr_div = (i_div < L_MIN_DIV) ? L_MIN_DIV : i_div;
        if (i_high == '0) begin
            w_wr_high = L_ONE;
        end else if (i_high >= w_wr_div) begin
            w_wr_high = w_wr_div - L_ONE;
        end else begin
            w_wr_high = i_high;
        end
    end

    assign w_running = r_run & i_en;
    assign w_wrap    = w_running & (r_cnt == r_act_div - L_ONE);
    // Pending config lands at a wrap, or at once when the channel is idle.
    assign w_apply    = r_pend & (~w_running | w_wrap);
    assign w_nxt_high = w_apply ? r_sh_high : r_act_high;

`ifdef CLKDIV_PHASE_EN
    logic [DIV_W-1:0] r_sh_phase;
    logic [DIV_W-1:0] r_act_phase;
    logic [DIV_W-1:0] w_wr_phase;

    assign w_wr_phase = (i_phase >= w_wr_div) ? w_wr_div - L_ONE : i_phase;
    assign w_start    = w_apply ? r_sh_phase : r_act_phase;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_sh_phase  <= '0;
            r_act_phase <= '0;
        end else begin
            if (i_we) begin
                r_sh_phase <= w_wr_phase;
            end
            if (w_apply) begin
                r_act_phase <= r_sh_phase;
            end
        end
    end
`else
    logic w_unused_phase;

    assign w_unused_phase = ^i_phase;
    assign w_start        = '0;
`endif

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_sh_div   <= L_MIN_DIV;
            r_sh_high  <= L_ONE;
            r_act_div  <= L_MIN_DIV;
            r_act_high <= L_ONE;
            r_pend     <= 1'b0;
        end else begin
            // A write coinciding with a wrap lands in the shadow after the
            // old shadow has been applied, so it stays pending.
            if (i_we) begin
                r_sh_div  <= w_wr_div;
                r_sh_high <= w_wr_high;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
            if (w_apply) begin
                r_act_div  <= r_sh_div;
                r_act_high <= r_sh_high;
            end
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_armed_nxt = r_armed;
        w_lock_nxt  = r_lock;
        if (!i_en) begin
            w_cnt_nxt   = w_start;
            w_armed_nxt = 1'b0;
            w_lock_nxt  = 1'b0;
        end else if (!r_run) begin
            w_cnt_nxt   = w_start;
            w_armed_nxt = (w_start == '0);
            w_lock_nxt  = 1'b0;
        end else if (w_wrap) begin
            // Lock needs a whole period, begun at count 0, under this config.
            w_cnt_nxt   = '0;
            w_armed_nxt = 1'b1;
            w_lock_nxt  = r_armed & ~w_apply;
        end else begin
            w_cnt_nxt = r_cnt + L_ONE;
        end
        if (i_we) begin
            w_lock_nxt = 1'b0;
        end
        w_clk_nxt = i_en & (w_cnt_nxt < w_nxt_high);
        w_stb_nxt = i_en & (w_cnt_nxt == '0);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_armed <= 1'b0;
            r_lock  <= 1'b0;
            r_clk   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_run   <= i_en;
            r_armed <= w_armed_nxt;
            r_lock  <= w_lock_nxt;
            r_clk   <= w_clk_nxt;
            r_stb   <= w_stb_nxt;
        end
    end

    assign o_clk  = r_clk;
    assign o_stb  = r_stb;
    assign o_lock = r_lock;

endmodule

// File: rtl/clk_div_mch.sv
// Multi-channel clock divider top: decodes the config channel and replicates clk_div_chan.
// Optional phase offset: define CLKDIV_PHASE_EN.
module clk_div_mch
    import clk_div_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DIV_W = DIV_W_DEF,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic [NCH-1:0]   clkout,
    output logic [NCH-1:0]   clkout_stb,
    output logic [NCH-1:0]   lock
);

    // Out-of-range channel numbers (non-power-of-2 NCH) are dropped here.
    logic w_ch_ok;

    assign w_ch_ok = (32'(cfg_ch) < 32'(NCH));

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            logic w_we;

            assign w_we = cfg_we & w_ch_ok & (cfg_ch == CH_W'(g));

            clk_div_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clkin   (clkin),
                .reset   (reset),
                .i_en    (ch_en[g]),
                .i_we    (w_we),
                .i_div   (cfg_div),
                .i_high  (cfg_high),
                .i_phase (cfg_phase),
                .o_clk   (clkout[g]),
                .o_stb   (clkout_stb[g]),
                .o_lock  (lock[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_mch.sv
// Bench for clk_div_mch (NCH=5): vector table, directed corner sequences and
// random traffic against a cycle model. Honours CLKDIV_PHASE_EN.
module tb_clk_div_mch;
    import clk_div_pkg::*;

    localparam int NCH   = 5;
    localparam int DIV_W = 16;
    localparam int CH_W  = 3;
`ifdef CLKDIV_PHASE_EN
    localparam bit PHASE_ON = 1'b1;
`else
    localparam bit PHASE_ON = 1'b0;
`endif

    logic             clkin = 1'b0;
    logic             reset;
    logic [NCH-1:0]   ch_en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_high;
    logic [DIV_W-1:0] cfg_phase;
    logic [NCH-1:0]   clkout;
    logic [NCH-1:0]   clkout_stb;
    logic [NCH-1:0]   lock;

    int checks = 0;
    int errors = 0;
    logic [NCH-1:0] g_en = '0;

    clk_div_mch #(
        .NCH   (NCH),
        .DIV_W (DIV_W)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .clkout     (clkout),
        .clkout_stb (clkout_stb),
        .lock       (lock)
    );

    always #5 clkin = ~clkin;

    // Reference: each channel is a position within its period plus the
    // configs in force and waiting.
    int m_ad[NCH], m_ah[NCH], m_ap[NCH];
    int m_sd[NCH], m_sh[NCH], m_sp[NCH];
    int m_pos[NCH];
    bit m_pend[NCH], m_run[NCH], m_armed[NCH];
    bit m_lock[NCH], m_clk[NCH], m_stb[NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_ad[i] = 2; m_ah[i] = 1; m_ap[i] = 0;
            m_sd[i] = 2; m_sh[i] = 1; m_sp[i] = 0;
            m_pos[i] = 0;
            m_pend[i] = 0; m_run[i] = 0; m_armed[i] = 0;
            m_lock[i] = 0; m_clk[i] = 0; m_stb[i] = 0;
        end
    endfunction

    function automatic void model_step(logic [NCH-1:0] en, bit we, int ch,
                                       int div, int high, int phase);
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            bit counting;
            bit wrap;
            bit apply;
            int d;
            int start;
            wr       = we && (ch == i);
            counting = m_run[i] && en[i];
            wrap     = counting && (m_pos[i] == m_ad[i] - 1);
            apply    = m_pend[i] && (!counting || wrap);
            if (apply) begin
                m_ad[i] = m_sd[i]; m_ah[i] = m_sh[i]; m_ap[i] = m_sp[i];
            end
            if (wr) begin
                d = (div < 2) ? 2 : div;
                m_sd[i] = d;
                m_sh[i] = (high == 0) ? 1 : ((high >= d) ? d - 1 : high);
                m_sp[i] = (phase >= d) ? d - 1 : phase;
                m_pend[i] = 1;
            end else if (apply) begin
                m_pend[i] = 0;
            end
            start = PHASE_ON ? m_ap[i] : 0;
            if (!en[i]) begin
                m_pos[i] = start; m_armed[i] = 0; m_lock[i] = 0;
            end else if (!m_run[i]) begin
                m_pos[i] = start; m_armed[i] = (start == 0); m_lock[i] = 0;
            end else if (wrap) begin
                m_pos[i] = 0; m_lock[i] = m_armed[i] && !apply; m_armed[i] = 1;
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
            if (wr) m_lock[i] = 0;
            m_run[i] = en[i];
            m_clk[i] = en[i] && (m_pos[i] < m_ah[i]);
            m_stb[i] = en[i] && (m_pos[i] == 0);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [NCH-1:0] e_clk, e_stb, e_lock;
        for (int i = 0; i < NCH; i++) begin
            e_clk[i] = m_clk[i]; e_stb[i] = m_stb[i]; e_lock[i] = m_lock[i];
        end
        check("model_clkout", 32'(clkout), 32'(e_clk));
        check("model_stb", 32'(clkout_stb), 32'(e_stb));
        check("model_lock", 32'(lock), 32'(e_lock));
    endtask

    task automatic tick(input bit we, input int ch, input int div, input int high, input int phase);
        reset = 1'b0; ch_en = g_en; cfg_we = we; cfg_ch = CH_W'(ch);
        cfg_div = DIV_W'(div); cfg_high = DIV_W'(high); cfg_phase = DIV_W'(phase);
        @(posedge clkin); #1;
        model_step(g_en, we, ch, div, high, phase);
        compare_model();
    endtask

    task automatic tick_idle();
        tick(1'b0, 0, 0, 0, 0);
    endtask

    task automatic rst_tick();
        reset = 1'b1; ch_en = g_en; cfg_we = 1'b0;
        @(posedge clkin); #1;
        model_reset();
        compare_model();
    endtask

    task automatic wait_stb(input int c, input int bound, output int n);
        n = 0;
        do begin
            tick_idle();
            n++;
        end while (clkout_stb[c] !== 1'b1 && n < bound);
        check("stb_seen", 32'(clkout_stb[c]), 32'd1);
    endtask

    typedef struct {
        logic         en0;
        logic         we;
        clk_div_cfg_t cfg;
        logic         e_clk;
        logic         e_stb;
        logic         e_lock;
    } vec_t;

    function automatic vec_t mk(logic en0, logic we, int div, int high,
                                logic c, logic s, logic l);
        vec_t v;
        v.en0 = en0; v.we = we;
        v.cfg.div = DIV_W_DEF'(div); v.cfg.high = DIV_W_DEF'(high); v.cfg.phase = '0;
        v.e_clk = c; v.e_stb = s; v.e_lock = l;
        return v;
    endfunction

    logic s2[800];
    logic s3[800];

    initial begin
        vec_t tbl[9];
        int n;
        int mism;
        int cnt2;
        int off;

        reset = 1'b1; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_div = '0; cfg_high = '0; cfg_phase = '0;
        model_reset();
        repeat (3) rst_tick();
        check("reset_clkout", 32'(clkout), 32'd0);
        check("reset_lock", 32'(lock), 32'd0);

        // ch0 div=5 high=2: 2-high/3-low, strobe every 5, lock 5 cycles after start
        tbl[0] = mk(1'b0, 1'b1, 5, 2, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        tbl[6] = mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        tbl[7] = mk(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        tbl[8] = mk(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            g_en[0] = tbl[k].en0;
            tick(tbl[k].we, 0, int'(tbl[k].cfg.div), int'(tbl[k].cfg.high), 0);
            check("tbl_clk", 32'(clkout[0]), 32'(tbl[k].e_clk));
            check("tbl_stb", 32'(clkout_stb[0]), 32'(tbl[k].e_stb));
            check("tbl_lock", 32'(lock[0]), 32'(tbl[k].e_lock));
        end

        // ch1: mid-period reconfiguration 4 -> 6
        tick(1'b1, 1, 4, 2, 0);
        g_en[1] = 1'b1;
        repeat (10) tick_idle();
        wait_stb(1, 10, n);
        tick_idle();
        tick(1'b1, 1, 6, 3, 0);
        check("c1_lock_drop", 32'(lock[1]), 32'd0);
        wait_stb(1, 12, n);
        check("c1_old_period", 32'(n + 2), 32'd4);
        check("c1_lock_at_apply", 32'(lock[1]), 32'd0);
        wait_stb(1, 12, n);
        check("c1_new_period", 32'(n), 32'd6);
        check("c1_lock_rise", 32'(lock[1]), 32'd1);

        // ch2: degenerate config clamps to D=2/H=1, then D=3/H=2
        tick(1'b1, 2, 0, 0, 0);
        g_en[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_idle();
            check("c2_d2_clk", 32'(clkout[2]), 32'((k % 2) == 0));
        end
        tick(1'b1, 2, 3, 7, 0);
        wait_stb(2, 8, n);
        check("c2_d3_clk0", 32'(clkout[2]), 32'd1);
        tick_idle();
        check("c2_d3_clk1", 32'(clkout[2]), 32'd1);
        tick_idle();
        check("c2_d3_clk2", 32'(clkout[2]), 32'd0);
        tick_idle();
        check("c2_d3_wrap", 32'(clkout_stb[2]), 32'd1);

        // ch2/ch3 div=8, phases 0 and 4, enabled together for 100 periods
        g_en[2] = 1'b0;
        g_en[3] = 1'b0;
        tick_idle();
        tick(1'b1, 2, 8, 4, 0);
        tick(1'b1, 3, 8, 4, 4);
        tick_idle();
        tick_idle();
        g_en[3:2] = 2'b11;
        for (int t = 0; t < 800; t++) begin
            tick_idle();
            s2[t] = clkout_stb[2];
            s3[t] = clkout_stb[3];
        end
        off = PHASE_ON ? 4 : 0;
        mism = 0;
        cnt2 = 0;
        for (int t = 0; t < 800; t++) begin
            if (s2[t]) cnt2++;
            if (s3[t] !== ((t >= off) ? s2[t - off] : 1'b0)) mism++;
        end
        check("phase_offset_mism", 32'(mism), 32'd0);
        check("phase_periods", 32'(cnt2), 32'd100);

        // ch0: reset at cnt=3 with a write pending
        wait_stb(0, 10, n);
        tick(1'b1, 0, 7, 3, 0);
        tick_idle();
        tick_idle();
        rst_tick();
        check("rst_clkout", 32'(clkout), 32'd0);
        check("rst_stb", 32'(clkout_stb), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        g_en = '0;
        rst_tick();
        tick_idle();
        g_en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_idle();
            check("rst_d2_clk", 32'(clkout[0]), 32'((k % 2) == 0));
            check("rst_d2_stb", 32'(clkout_stb[0]), 32'((k % 2) == 0));
        end

        // Out-of-range channel writes are ignored
        tick(1'b1, 0, 4, 2, 0);
        tick(1'b1, 1, 6, 3, 0);
        g_en[1:0] = 2'b11;
        repeat (16) tick_idle();
        check("oor_locked_before", 32'(lock[1:0]), 32'd3);
        tick(1'b1, 5, 3, 1, 0);
        tick(1'b1, 7, 2, 1, 0);
        repeat (12) tick_idle();
        check("oor_locked_after", 32'(lock[1:0]), 32'd3);
        wait_stb(0, 8, n);
        wait_stb(0, 8, n);
        check("oor_ch0_period", 32'(n), 32'd4);

        // Random traffic against the model
        for (int r = 0; r < 3000; r++) begin
            int idx;
            if ($urandom_range(9) == 0) begin
                idx = int'($urandom_range(NCH - 1));
                g_en[idx] = ~g_en[idx];
            end
            if ($urandom_range(6) == 0) begin
                tick(1'b1, int'($urandom_range(7)), int'($urandom_range(12)),
                     int'($urandom_range(14)), int'($urandom_range(12)));
            end else begin
                tick_idle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_mch.md
CLK_DIV_MCH -- requirements
Module: clk_div_mch

Interface
REQ-001 SHALL provide parameter NCH, default 4, as the number of independent divider channels (1..16).
REQ-002 SHALL provide parameter DIV_W, default 16, as the width of the divide, high-time and phase fields.
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 SHALL provide port clkin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL provide port ch_en, input, NCH bits: per-channel run enable.
REQ-007 SHALL provide port cfg_we, input, 1 bit: config write strobe, one cycle.
REQ-008 SHALL provide port cfg_ch, input, $clog2(NCH) bits (minimum 1): target channel.
REQ-009 SHALL provide port cfg_div, input, DIV_W bits: period in clkin cycles.
REQ-010 SHALL provide port cfg_high, input, DIV_W bits: high time in clkin cycles.
REQ-011 SHALL provide port cfg_phase, input, DIV_W bits: start offset in cycles.
REQ-012 SHALL provide port clkout, output, NCH bits: registered divided waveform per channel.
REQ-013 SHALL provide port clkout_stb, output, NCH bits: one-cycle strobe at each period start (count==0).
REQ-014 SHALL provide port lock, output, NCH bits: high while the channel runs the active config and has completed at least one full period with it.

Function
REQ-015 SHALL keep, per channel, a counter cnt that counts 0..D-1 and wraps to 0, where D is the active divide value.
REQ-016 SHALL compute D as max(cfg_div, 2): a written cfg_div of 0 or 1 becomes 2.
REQ-017 SHALL compute H by clamping cfg_high: 0 becomes 1, and any value >= D becomes D-1.
REQ-018 SHALL drive clkout[i] = (cnt < H) as a registered value, so the output is glitch-free.
REQ-019 SHALL assert clkout_stb[i] in exactly the cycle where cnt==0 while the channel is running.
REQ-020 SHALL latch a write with cfg_we=1 and a valid cfg_ch into that channel's shadow registers and set its pending flag.
REQ-021 SHALL ignore a write whose cfg_ch >= NCH.
REQ-022 SHALL treat a second write before a pending write is applied as replacing it (last write wins).
REQ-023 SHALL apply a pending shadow config only at the wrap cycle (cnt==D-1 → 0), so the current period always completes with the old D/H.
REQ-024 SHALL apply a pending config immediately, with no wrap, if the channel is not running.
REQ-025 SHALL clear lock[i] in the cycle after any accepted write to channel i.
REQ-026 SHALL set lock[i] at the first wrap that follows a full period run with the new config.
REQ-027 SHALL, when ch_en[i] is low, hold clkout[i]=0, clkout_stb[i]=0 and lock[i]=0; the counter holds at its start value.
REQ-028 SHALL, on a ch_en[i] rise, start counting from its start value on the next cycle; lock rises after the first full period.
REQ-029 SHALL, if cfg_we and a wrap occur in the same cycle on the same channel, apply the old shadow at that wrap and keep the new write pending.
REQ-030 SHALL keep channels fully independent: no shared counter, and no cross-channel phase drift once they run.

Reset
REQ-031 SHALL, on reset, set cnt=0, clkout=0, clkout_stb=0, lock=0 and pending=0 for every channel.
REQ-032 SHALL, on reset, set the shadow and active config to D=2, H=1 and phase=0.
REQ-033 SHALL, when reset is asserted mid-period, take it on the next edge and discard any pending write.

Configuration
REQ-034 SHALL implement phase-offset support under macro CLKDIV_PHASE_EN.
REQ-035 SHALL, with CLKDIV_PHASE_EN defined, latch cfg_phase with each write, clamp it to D-1, and use it as the counter start value on ch_en rise or while disabled.
REQ-036 SHALL, without CLKDIV_PHASE_EN, ignore cfg_phase, always use start value 0, and synthesise no phase storage.

Structure
REQ-037 SHALL place in shared package clk_div_pkg: the default DIV_W, the minimum-divide constant (2), and a typedef for the per-channel config record {div, high, phase}.
REQ-038 SHALL use one sub-module, clk_div_chan: the per-channel counter, shadow/active registers, pending logic and lock.
REQ-039 SHALL have the top level only decode cfg_ch and instantiate NCH instances of clk_div_chan using generate.

Verification
REQ-040 SHALL verify: write ch0 div=5 high=2, then ch_en[0]=1 → clkout[0] is a 2-high/3-low pattern, the strobe repeats every 5 cycles, and lock[0] rises 5 cycles after start.
REQ-041 SHALL verify: ch1 running div=4; mid-period write div=6 high=3 → the current period ends at 4 cycles, later periods are 6 cycles, lock[1] drops then rises after 6 cycles.
REQ-042 SHALL verify: write div=0 high=0, then div=3 high=7 → effective D=2/H=1, then D=3/H=2, with no zero-width pulse.
REQ-043 SHALL verify: with CLKDIV_PHASE_EN, ch2 and ch3 both div=8, phase 0 and 4, enabled in the same cycle → the strobes are offset by exactly 4 cycles, sustained for 100 periods.
REQ-044 SHALL verify: reset asserted at cnt=3 with a write pending → the next cycle has all outputs 0 and the pending flag cleared; after release and enable, the channel runs D=2.
REQ-045 SHALL verify: write to cfg_ch=NCH (out of range, NCH non-power-of-2 build) → no channel's config or lock changes.
